// File: rtl/io_pkg.sv
// Shared definitions for the IO block: select codes, draw modes and the
// text-sequencer state type.
package io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_DRAW,
    ST_GAP,
    ST_DONE
  } seq_state_t;

  localparam logic [1:0] IO_7SEG = 2'd0;
  localparam logic [1:0] IO_SW   = 2'd1;
  localparam logic [1:0] IO_KB   = 2'd2;
  localparam logic [1:0] IO_VGA  = 2'd3;

  localparam logic [1:0] DRAW_PIXEL = 2'd0;
  localparam logic [1:0] DRAW_CHAR  = 2'd1;

  localparam int unsigned GLYPH_PIXELS = 64;

endpackage

// File: rtl/vga_text_cursor.sv
// Text cursor: loads the string origin, then steps one glyph right or wraps
// back to the origin column one glyph row down.
module vga_text_cursor #(
  parameter int unsigned GLYPH_W    = 8,
  parameter int unsigned GLYPH_H    = 8,
  parameter int unsigned LINE_WIDTH = 640
) (
  input  logic        Slow_Clock,
  input  logic        Reset,
  input  logic        Load,
  input  logic        Advance,
  input  logic        Wrap,
  input  logic [31:0] Load_X,
  input  logic [31:0] Load_Y,
  output logic        Line_Full,
  output logic [31:0] X,
  output logic [31:0] Y
);

  localparam logic [31:0] STEP_X  = 32'(GLYPH_W);
  localparam logic [31:0] STEP_Y  = 32'(GLYPH_H);
  localparam logic [31:0] X_LIMIT = 32'(LINE_WIDTH - GLYPH_W);

  logic [31:0] home_x;

  // Next glyph would start past the last legal column (32-bit wrapping add).
  assign Line_Full = (X + STEP_X) > X_LIMIT;

  // Cursor position and the column to return to on a line wrap.
  always_ff @(posedge Slow_Clock) begin
    if (Reset) begin
      home_x <= '0;
      X      <= '0;
      Y      <= '0;
    end else if (Load) begin
      home_x <= Load_X;
      X      <= Load_X;
      Y      <= Load_Y;
    end else if (Advance) begin
      if (Wrap) begin
        X <= home_x;
        Y <= Y + STEP_Y;
      end else begin
        X <= X + STEP_X;
      end
    end
  end

endmodule

// File: rtl/vga_text_sequencer.sv
// Fetches a zero-terminated string one word per character and drives the IO
// block's character-draw interface for one glyph period per character.
module vga_text_sequencer
  import io_pkg::*;
#(
  parameter int unsigned GLYPH_PIXELS = io_pkg::GLYPH_PIXELS,
  parameter int unsigned GLYPH_W      = 8,
  parameter int unsigned GLYPH_H      = 8,
  parameter int unsigned LINE_WIDTH   = 640,
  parameter int unsigned MAX_LEN      = 255
) (
  input  logic        Slow_Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Abort,
  input  logic [31:0] Str_Addr,
  input  logic [31:0] Start_X,
  input  logic [31:0] Start_Y,
  input  logic [31:0] Text_Color,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic [31:0] Mem_Data,
  input  logic        Mem_Valid,
  output logic        IO_Enable,
  output logic [1:0]  IO_Sel,
  output logic [1:0]  Draw_Select,
  output logic [31:0] Data_1,
  output logic [31:0] Data_2,
  output logic [31:0] Data_3,
  output logic [31:0] Draw_Text_Color,
  output logic        Busy,
  output logic        Done,
  output logic [7:0]  Chars_Drawn
);

  localparam int unsigned      PIX_W    = $clog2(GLYPH_PIXELS);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(GLYPH_PIXELS - 1);
  localparam logic [7:0]       MAX_IDX  = 8'(MAX_LEN);

  seq_state_t       state;
  logic [31:0]      base_addr;
  logic [31:0]      color;
  logic [6:0]       glyph;
  logic [7:0]       idx;
  logic [PIX_W-1:0] pix_cnt;

  logic        cur_load;
  logic        cur_advance;
  logic        line_full;
  logic [31:0] cur_x;
  logic [31:0] cur_y;
  logic        unused_mem_bits;

  // The character index doubles as the drawn-glyph count: both clear at
  // Start and step together in GAP, and Abort leaves both untouched.
  assign Chars_Drawn     = idx;
  assign Mem_Addr        = base_addr + 32'(idx);
  assign Draw_Select     = DRAW_CHAR;
  assign Data_1          = cur_x;
  assign Data_2          = cur_y;
  assign Data_3          = {25'd0, glyph};
  assign Draw_Text_Color = color;
  assign unused_mem_bits = ^Mem_Data[31:7];

  assign cur_load    = (state == ST_IDLE) && Start && !Abort;
  assign cur_advance = (state == ST_GAP) && !Abort;

  vga_text_cursor #(
    .GLYPH_W    (GLYPH_W),
    .GLYPH_H    (GLYPH_H),
    .LINE_WIDTH (LINE_WIDTH)
  ) u_cursor (
    .Slow_Clock (Slow_Clock),
    .Reset      (Reset),
    .Load       (cur_load),
    .Advance    (cur_advance),
    .Wrap       (line_full),
    .Load_X     (Start_X),
    .Load_Y     (Start_Y),
    .Line_Full  (line_full),
    .X          (cur_x),
    .Y          (cur_y)
  );

  // Sequencer FSM; every interface strobe is registered on the transition
  // into the state that owns it.
  always_ff @(posedge Slow_Clock) begin
    if (Reset) begin
      state     <= ST_IDLE;
      base_addr <= '0;
      color     <= '0;
      glyph     <= '0;
      idx       <= '0;
      pix_cnt   <= '0;
      Mem_Req   <= 1'b0;
      IO_Enable <= 1'b0;
      IO_Sel    <= IO_7SEG;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else if (Abort) begin
      state     <= ST_IDLE;
      Mem_Req   <= 1'b0;
      IO_Enable <= 1'b0;
      IO_Sel    <= IO_7SEG;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            base_addr <= Str_Addr;
            color     <= Text_Color;
            idx       <= '0;
            Mem_Req   <= 1'b1;
            Busy      <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (Mem_Valid) begin
            glyph   <= Mem_Data[6:0];
            Mem_Req <= 1'b0;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (glyph == 7'd0 || idx == MAX_IDX) begin
            Done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            pix_cnt   <= '0;
            IO_Enable <= 1'b1;
            IO_Sel    <= IO_VGA;
            state     <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (pix_cnt == LAST_PIX) begin
            IO_Enable <= 1'b0;
            IO_Sel    <= IO_7SEG;
            state     <= ST_GAP;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          idx     <= idx + 8'd1;
          Mem_Req <= 1'b1;
          state   <= ST_FETCH;
        end
        ST_DONE: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_sequencer.sv
// Bench for vga_text_sequencer: two instances (default length cap and a cap
// of 3) share stimulus; the selected one is driven, observed and served by a
// word-addressed memory with a programmable wait.
module tb_vga_text_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset = 1'b1, Start = 1'b0, Abort = 1'b0, sel = 1'b0;
  logic [31:0] Str_Addr = '0, Start_X = '0, Start_Y = '0, Text_Color = '0;
  logic [31:0] Mem_Data = '0;
  logic        Mem_Valid = 1'b0;

  logic        req_o [2], en_o [2], busy_o [2], done_o [2];
  logic [1:0]  iosel_o [2], dsel_o [2];
  logic [31:0] addr_o [2], d1_o [2], d2_o [2], d3_o [2], col_o [2];
  logic [7:0]  chars_o [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    vga_text_sequencer #(
      .MAX_LEN (g == 1 ? 3 : 255)
    ) u_dut (
      .Slow_Clock      (clk),
      .Reset           (Reset),
      .Start           (Start && (int'(sel) == g)),
      .Abort           (Abort),
      .Str_Addr        (Str_Addr),
      .Start_X         (Start_X),
      .Start_Y         (Start_Y),
      .Text_Color      (Text_Color),
      .Mem_Req         (req_o[g]),
      .Mem_Addr        (addr_o[g]),
      .Mem_Data        (Mem_Data),
      .Mem_Valid       (Mem_Valid && (int'(sel) == g)),
      .IO_Enable       (en_o[g]),
      .IO_Sel          (iosel_o[g]),
      .Draw_Select     (dsel_o[g]),
      .Data_1          (d1_o[g]),
      .Data_2          (d2_o[g]),
      .Data_3          (d3_o[g]),
      .Draw_Text_Color (col_o[g]),
      .Busy            (busy_o[g]),
      .Done            (done_o[g]),
      .Chars_Drawn     (chars_o[g])
    );
  end

  int unsigned n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [31:0] mem [1024];

  typedef struct {
    int unsigned start, len;
    logic [31:0] x, y, code, color;
  } run_t;

  run_t        runs_q [$];
  int unsigned done_q [$];
  int unsigned cyc = 0, t0 = 0, wait_n = 0, wcnt = 0;
  int unsigned unstable = 0, iosel_bad = 0, dsel_bad = 0, req_bad = 0;
  logic        in_run = 1'b0, chk_req = 1'b0, prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  run_t        cur;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the selected instance, then act as its memory for this cycle.
  always @(negedge clk) begin
    if (en_o[sel]) begin
      if (!in_run) begin
        in_run    = 1'b1;
        cur.start = cyc - t0;
        cur.len   = 1;
        cur.x     = d1_o[sel];
        cur.y     = d2_o[sel];
        cur.code  = d3_o[sel];
        cur.color = col_o[sel];
      end else begin
        cur.len++;
        if (d1_o[sel] !== cur.x || d2_o[sel] !== cur.y ||
            d3_o[sel] !== cur.code || col_o[sel] !== cur.color)
          unstable++;
      end
    end else if (in_run) begin
      in_run = 1'b0;
      runs_q.push_back(cur);
    end
    if (iosel_o[sel] !== (en_o[sel] ? 2'd3 : 2'd0)) iosel_bad++;
    if (dsel_o[sel] !== 2'd1) dsel_bad++;
    if (done_o[sel]) done_q.push_back(cyc - t0);
    if (chk_req && prev_req && !Mem_Valid &&
        (!req_o[sel] || addr_o[sel] !== prev_addr))
      req_bad++;
    prev_req  = req_o[sel];
    prev_addr = addr_o[sel];
    if (req_o[sel]) begin
      if (wcnt == wait_n) begin
        Mem_Valid = 1'b1;
        Mem_Data  = mem[addr_o[sel][9:0]];
        wcnt      = 0;
      end else begin
        Mem_Valid = 1'b0;
        wcnt++;
      end
    end else begin
      Mem_Valid = 1'b0;
      wcnt      = 0;
    end
  end

  task automatic put_word(input logic [31:0] a, input logic [6:0] code);
    mem[10'(a)] = ($urandom() & 32'hFFFF_FF80) | {25'd0, code};
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_busy"},  32'(busy_o[sel]),  0);
    check_eq({tag, "_done"},  32'(done_o[sel]),  0);
    check_eq({tag, "_req"},   32'(req_o[sel]),   0);
    check_eq({tag, "_en"},    32'(en_o[sel]),    0);
    check_eq({tag, "_iosel"}, 32'(iosel_o[sel]), 0);
    check_eq({tag, "_dsel"},  32'(dsel_o[sel]),  1);
    check_eq({tag, "_d1"},    d1_o[sel],         0);
    check_eq({tag, "_d2"},    d2_o[sel],         0);
    check_eq({tag, "_d3"},    d3_o[sel],         0);
    check_eq({tag, "_color"}, col_o[sel],        0);
    check_eq({tag, "_addr"},  addr_o[sel],       0);
    check_eq({tag, "_chars"}, 32'(chars_o[sel]), 0);
  endtask

  // Start one string and compare the observed draw sequence against a model
  // built from the string contents and the per-character cycle budget.
  // abort_at / poke_at / reset_at are cycle numbers after acceptance (0 = none).
  task automatic run_string(input string tag, input logic [31:0] addr, sx, sy, color,
                            input int unsigned wn, abort_at, poke_at, reset_at);
    int unsigned n, maxl, cost, done_c, stop, fall_act, exp_runs, exp_chars, ds, len;
    logic [31:0] x, y, w;
    logic [31:0] ex [$], ey [$], ec [$];
    logic        done_exp;

    maxl = sel ? 3 : 255;
    x = sx;
    y = sy;
    n = 0;
    while (n < maxl) begin
      w = mem[10'(addr + n)];
      if (w[6:0] == 7'd0) break;
      ex.push_back(x);
      ey.push_back(y);
      ec.push_back({25'd0, w[6:0]});
      if (x + 32'd8 > 32'd632) begin
        x = sx;
        y = y + 32'd8;
      end else begin
        x = x + 32'd8;
      end
      n++;
    end
    cost     = 67 + wn;
    done_c   = 1 + n * cost + wn + 2;
    stop     = (abort_at != 0 && abort_at < done_c) ? abort_at : done_c;
    done_exp = (abort_at == 0 || abort_at >= done_c);

    runs_q.delete();
    done_q.delete();
    in_run    = 1'b0;
    unstable  = 0;
    iosel_bad = 0;
    dsel_bad  = 0;
    req_bad   = 0;
    wait_n    = wn;
    chk_req   = (abort_at == 0 && reset_at == 0);

    Str_Addr   = addr;
    Start_X    = sx;
    Start_Y    = sy;
    Text_Color = color;
    Start      = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc - 1;
    Start = 1'b0;

    fall_act = 0;
    for (int unsigned rel = 1; rel < 20000; rel++) begin
      @(negedge clk);
      if (!busy_o[sel]) begin
        fall_act = rel;
        break;
      end
      Start      = (rel == poke_at);
      Abort      = (rel == abort_at);
      Reset      = (rel == reset_at);
      Str_Addr   = $urandom();
      Start_X    = $urandom();
      Start_Y    = $urandom();
      Text_Color = $urandom();
    end
    Start = 1'b0;
    Abort = 1'b0;
    Reset = 1'b0;
    #1;

    if (reset_at != 0) begin
      check_eq({tag, "_fall"}, fall_act, reset_at + 1);
      check_reset_values({tag, "_rst"});
      return;
    end

    check_eq({tag, "_busy_fall"}, fall_act, stop + 1);
    exp_runs  = 0;
    exp_chars = 0;
    for (int unsigned k = 0; k < n; k++) begin
      ds = 1 + k * cost + wn + 2;
      if (ds <= stop) exp_runs++;
      if (ds + 64 < stop) exp_chars++;
    end
    check_eq({tag, "_runs"}, runs_q.size(), exp_runs);
    for (int unsigned k = 0; k < exp_runs && k < runs_q.size(); k++) begin
      ds  = 1 + k * cost + wn + 2;
      len = (stop - ds + 1 < 64) ? stop - ds + 1 : 64;
      check_eq({tag, "_start"}, runs_q[k].start, ds);
      check_eq({tag, "_len"},   runs_q[k].len,   len);
      check_eq({tag, "_x"},     runs_q[k].x,     ex[k]);
      check_eq({tag, "_y"},     runs_q[k].y,     ey[k]);
      check_eq({tag, "_code"},  runs_q[k].code,  ec[k]);
      check_eq({tag, "_color"}, runs_q[k].color, color);
    end
    check_eq({tag, "_done_cnt"}, done_q.size(), done_exp ? 1 : 0);
    if (done_exp && done_q.size() > 0) check_eq({tag, "_done_cyc"}, done_q[0], done_c);
    check_eq({tag, "_chars"},    32'(chars_o[sel]), exp_chars);
    check_eq({tag, "_en_after"}, 32'(en_o[sel]),    0);
    check_eq({tag, "_req_after"},32'(req_o[sel]),   0);
    check_eq({tag, "_stable"},   unstable,          0);
    check_eq({tag, "_iosel"},    iosel_bad,         0);
    check_eq({tag, "_dsel"},     dsel_bad,          0);
    check_eq({tag, "_req_hold"}, req_bad,           0);
  endtask

  initial begin
    int unsigned len, wn;
    logic [31:0] a, sx;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    Reset = 1'b0;
    @(negedge clk);

    // "HI" at 0x40 from (16,24)
    put_word(32'h40, 7'h48);
    put_word(32'h41, 7'h49);
    put_word(32'h42, 7'h00);
    run_string("hi", 32'h40, 32'd16, 32'd24, 32'h00FF_00AA, 0, 0, 0, 0);

    // Back-to-back start; 624 stays on the line once, then wraps
    for (int i = 0; i < 3; i++) put_word(32'h80 + i, 7'(8'h41 + i));
    put_word(32'h83, 7'h00);
    run_string("edge624", 32'h80, 32'd624, 32'd100, 32'h1234_5678, 0, 0, 0, 0);

    // Last legal column wraps immediately, Y crossing 2^32
    run_string("edge632", 32'h80, 32'd632, 32'hFFFF_FFF8, 32'h0BAD_F00D, 0, 0, 0, 0);

    // Five wait cycles per word
    run_string("wait5", 32'h40, 32'd0, 32'd0, 32'h0000_0007, 5, 0, 0, 0);

    // Empty string
    put_word(32'h100, 7'h00);
    run_string("empty", 32'h100, 32'd40, 32'd40, 32'h1, 0, 0, 0, 0);

    // Abort at DRAW cycle 30 of the second character
    run_string("abort", 32'h80, 32'd8, 32'd8, 32'hCAFE_0001, 0, 1 + 67 + 2 + 30, 0, 0);

    // Start pulsed mid-draw is ignored
    run_string("poke", 32'h80, 32'd64, 32'd16, 32'h0000_FFFF, 1, 0, 20, 0);

    // Randomized strings, including addresses that wrap past 2^32
    for (int t = 0; t < 10; t++) begin
      len = $urandom_range(4, 0);
      wn  = $urandom_range(3, 0);
      a   = (t % 4 == 3) ? 32'hFFFF_FFFE : 32'($urandom_range(1000, 0));
      sx  = (t % 2 == 0) ? 32'($urandom_range(632, 600)) : 32'($urandom_range(70, 0) * 8);
      for (int unsigned i = 0; i < len; i++) put_word(a + i, 7'($urandom_range(127, 1)));
      put_word(a + len, 7'h00);
      run_string("rand", a, sx, $urandom(), $urandom(), wn, 0, 0, 0);
    end

    // Reset during the second character's FETCH wait
    run_string("rstfetch", 32'h80, 32'd48, 32'd48, 32'hFFFF_FFFF, 5, 0, 0, 1 + 72 + 3);

    // Length cap of 3 on an unterminated 10-character string
    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) put_word(32'h200 + i, 7'($urandom_range(127, 1)));
    run_string("cap3", 32'h200, 32'd0, 32'd0, 32'h00C0_FFEE, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
